cipher_round_ctrl: RTL
======================

# cipher_round_ctrl

Sequencing controller for the iterative AES-128 cipher datapath. It accepts an encrypt request through a valid/ready handshake and drives the datapath enables one round per cycle: initial AddRoundKey, rounds 1..9 (SubBytes, ShiftRows, MixColumns, AddRoundKey), then final round 10 without MixColumns. It also sequences the round-key expansion register and generates the round constant, then holds the result until the consumer accepts it.

## Interface
Parameters:
- ROUNDS, 10: number of cipher rounds; only 10 (AES-128) is legal, and any other value is an elaboration error.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start_valid  in  1  request to encrypt the plaintext/key currently presented at the datapath inputs.
- start_ready  out  1  controller can accept a request (IDLE only).
- hold  in  1  stall: freezes round progress while in ROUND.
- out_valid  out  1  datapath state register holds the ciphertext.
- out_ready  in  1  consumer accepts the ciphertext.
- state_load  out  1  datapath loads plaintext XOR cipher key into the state register.
- key_load  out  1  key register loads the cipher key.
- round_en  out  1  datapath state register captures the round output.
- mix_en  out  1  MixColumns included in the round path (otherwise bypassed).
- key_step  out  1  key register advances to the next round key.
- rcon  out  8  round constant for the current key step.
- round  out  4  current round index, 0..10.
- busy  out  1  request in flight (ROUND or DONE).

## Operation
- States:
  - IDLE: start_ready=1. On start_valid=1, go to ROUND with round=1.
  - ROUND:
    - hold=0: assert round_en and key_step. If round=10, go to DONE; otherwise round increments.
    - hold=1: round_en=0, key_step=0, and round and rcon hold.
  - DONE: out_valid=1. On out_ready=1, go to IDLE. hold is ignored.
- state_load = key_load = start_valid AND start_ready (combinational, handshake cycle only).
- round_en, key_step, mix_en, rcon, out_valid, busy and start_ready decode from registered state only. They are Moore outputs with no combinational path from any input, except that round_en and key_step are gated by hold.
- mix_en = 1 in ROUND when round is 1..9. It is 0 in round 10 and in every other state.
- rcon:
  - Internal register, 0x01 at request acceptance.
  - Each advancing round cycle updates it to xtime(rcon): shift left 1, XOR 0x1B if bit 7 was set, all mod 2^8.
  - Sequence: 01,02,04,08,10,20,40,80,1B,36.
  - Output equals the register in ROUND and 0x00 otherwise.
- round output is 0 in IDLE, 1..10 in ROUND, and 10 in DONE.
- start_valid outside IDLE is ignored; no request is queued.
- out_ready outside DONE is ignored.

## Timing
- Reset values (asynchronous, immediate): state IDLE, start_ready=1, out_valid=0, busy=0, round=0, rcon=0x00 (internal 0x01), round_en=key_step=mix_en=0, state_load/key_load follow start_valid.
- Reset mid-operation aborts the request with no out_valid. Operation resumes normally from IDLE on the first edge after rst deasserts.
- Latency with no hold: handshake in cycle 0, ROUND in cycles 1..10, out_valid=1 from cycle 11. With N stall cycles, out_valid rises at cycle 11+N.
- out_valid stays high until out_ready is sampled high. If out_ready=1 in the first DONE cycle, start_ready=1 in cycle 12, so minimum spacing between requests is 12 cycles.
- hold asserted in the same cycle as the round-10 step: the step is suppressed and the DONE transition is delayed.

## Test plan
- Single request, hold=0, out_ready=1:
  - state_load/key_load pulse in cycle 0, round=1..10 in cycles 1..10, mix_en=0 only in cycle 10, and out_valid=1 in cycle 11 only.
  - With the datapath attached and key 2b7e151628aed2a6abf7158809cf4f3c, plaintext 3243f6a8885a308d313198a2e0370734 produces 3925841d02dc09fbdc118597196a0b32.
- rcon check: rcon sampled on each key_step = 01,02,04,08,10,20,40,80,1B,36, and 00 in IDLE and DONE.
- Stall: hold=1 for 3 cycles at round=5 gives round stuck at 5 with round_en=key_step=0. out_valid then rises at cycle 14 and the ciphertext is unchanged.
- Backpressure and ignored start:
  - out_ready=0 for 4 cycles in DONE holds out_valid=1 and round=10.
  - start_valid=1 throughout gives start_ready=0 and no state_load until the cycle after out_ready.
- Reset at round=6: all outputs return to reset values immediately. The next request completes normally with the correct ciphertext.

Source files
------------

// File: rtl/cipher_round_ctrl_if.sv
// Handshake and datapath-control bundle between the AES-128 round controller and its environment.
// master = requester/datapath side, slave = controller side.
interface cipher_round_ctrl_if;
  logic       start_valid;
  logic       start_ready;
  logic       hold;
  logic       out_valid;
  logic       out_ready;
  logic       state_load;
  logic       key_load;
  logic       round_en;
  logic       mix_en;
  logic       key_step;
  logic [7:0] rcon;
  logic [3:0] round;
  logic       busy;

  modport master (
    output start_valid, hold, out_ready,
    input  start_ready, out_valid, state_load, key_load, round_en, mix_en,
           key_step, rcon, round, busy
  );

  modport slave (
    input  start_valid, hold, out_ready,
    output start_ready, out_valid, state_load, key_load, round_en, mix_en,
           key_step, rcon, round, busy
  );
endinterface

// File: rtl/cipher_round_ctrl.sv
// AES-128 round sequencer: one round per cycle, ciphertext valid 11 cycles after accept (+1 per hold cycle).
// hold freezes rounds; the result is held in DONE until out_ready, and new requests wait until IDLE.
module cipher_round_ctrl #(
  parameter int ROUNDS = 10
) (
  input logic                clk,
  input logic                rst,
  cipher_round_ctrl_if.slave bus
);

  generate
    if (ROUNDS != 10) begin : g_rounds_check
      $error("cipher_round_ctrl: only ROUNDS=10 (AES-128) is supported");
    end
  endgenerate

  localparam logic [3:0] LAST_ROUND = 4'(ROUNDS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_round;
  logic [3:0] w_round_nxt;
  logic [7:0] r_rcon;
  logic [7:0] w_rcon_nxt;
  logic       w_accept;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_round <= 4'd0;
      r_rcon  <= 8'h01;
    end else begin
      r_state <= w_state_nxt;
      r_round <= w_round_nxt;
      r_rcon  <= w_rcon_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_round_nxt     = r_round;
    w_rcon_nxt      = r_rcon;
    w_accept        = 1'b0;
    bus.start_ready = 1'b0;
    bus.out_valid   = 1'b0;
    bus.round_en    = 1'b0;
    bus.key_step    = 1'b0;
    bus.mix_en      = 1'b0;
    bus.rcon        = 8'h00;
    bus.busy        = 1'b0;

    case (r_state)
      S_IDLE: begin
        bus.start_ready = 1'b1;
        w_accept        = bus.start_valid;
        if (bus.start_valid) begin
          w_state_nxt = S_ROUND;
          w_round_nxt = 4'd1;
          w_rcon_nxt  = 8'h01;
        end
      end
      S_ROUND: begin
        bus.busy   = 1'b1;
        bus.mix_en = (r_round != LAST_ROUND);
        bus.rcon   = r_rcon;
        // hold only gates the step strobes; the Moore outputs stay put
        if (!bus.hold) begin
          bus.round_en = 1'b1;
          bus.key_step = 1'b1;
          w_rcon_nxt   = xtime(r_rcon);
          if (r_round == LAST_ROUND) begin
            w_state_nxt = S_DONE;
          end else begin
            w_round_nxt = r_round + 4'd1;
          end
        end
      end
      S_DONE: begin
        bus.busy      = 1'b1;
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          w_state_nxt = S_IDLE;
          w_round_nxt = 4'd0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_round_nxt = 4'd0;
      end
    endcase

    bus.state_load = w_accept;
    bus.key_load   = w_accept;
    bus.round      = r_round;
  end

endmodule
